buffered_ring_interface: RTL and testbench

- Parametrised successor to the single-register leaf bus interface on the packet ring/bus network.
- Adds an injection FIFO (PE -> bus) and an ejection FIFO (bus -> PE), each with valid/ready handshakes, so the PE never loses a packet and never has to resend.
- When the ejection FIFO is full, a packet addressed to this leaf is deflected back onto the bus, and a saturating counter records each deflection.
- Sits between one leaf PE and its bus segment; packet format is unchanged.

---
 rtl/buffered_ring_interface_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/buffered_ring_interface.sv | 136 +++++++++++++
 tb/tb_buffered_ring_interface.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/buffered_ring_interface_pkg.sv
// Shared packet-field helpers for ring/bus nodes and leaves.
// Packet layout: [valid | dst | payload], valid in the MSB.
package buffered_ring_interface_pkg;

  // Per-cycle decision for the outgoing bus slot.
  typedef enum logic [1:0] {
    SlotIdle,
    SlotTransit,
    SlotEject,
    SlotDeflect
  } slot_e;

  localparam logic [15:0] DeflectMax = 16'hFFFF;

  // Destination field width; kept at least one bit wide.
  function automatic int unsigned addr_width(int unsigned num_leaves);
    return (num_leaves > 1) ? $clog2(num_leaves) : 1;
  endfunction

  function automatic int unsigned pkt_width(int unsigned num_leaves, int unsigned payload_sz);
    return 1 + addr_width(num_leaves) + payload_sz;
  endfunction

  function automatic int unsigned valid_idx(int unsigned num_leaves, int unsigned payload_sz);
    return pkt_width(num_leaves, payload_sz) - 1;
  endfunction

  function automatic int unsigned dst_hi(int unsigned num_leaves, int unsigned payload_sz);
    return pkt_width(num_leaves, payload_sz) - 2;
  endfunction

  function automatic int unsigned dst_lo(int unsigned payload_sz);
    return payload_sz;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read.
// Ports: clk, reset (sync, active-high), push/din, pop/dout, full, empty, count.
// DEPTH must be a power of two (pointers wrap by natural overflow), at least 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PtrW'(1);
    if (do_pop)  rd_d = rd_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; a zero count makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/buffered_ring_interface.sv
// Leaf bus interface with injection (PE -> bus) and ejection (bus -> PE) FIFOs.
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   bus_i / bus_o           upstream slot in, registered downstream slot out
//   pe_in_data/valid/ready  PE injection handshake
//   pe_out_data/valid/ready PE ejection handshake (FWFT head)
//   deflect_count           saturating count of local packets bounced back onto the bus
module buffered_ring_interface
  import buffered_ring_interface_pkg::*;
#(
  parameter int unsigned num_leaves = 2,
  parameter int unsigned payload_sz = 1,
  parameter int unsigned addr       = 0,
  parameter int unsigned inj_depth  = 4,
  parameter int unsigned ej_depth   = 4,
  parameter int unsigned p_sz       = pkt_width(num_leaves, payload_sz)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [p_sz-1:0] bus_i,
  output logic [p_sz-1:0] bus_o,
  input  logic [p_sz-1:0] pe_in_data,
  input  logic            pe_in_valid,
  output logic            pe_in_ready,
  output logic [p_sz-1:0] pe_out_data,
  output logic            pe_out_valid,
  input  logic            pe_out_ready,
  output logic [15:0]     deflect_count
);

  localparam int unsigned AddrW    = addr_width(num_leaves);
  localparam int unsigned ValidIdx = valid_idx(num_leaves, payload_sz);
  localparam int unsigned DstHi    = dst_hi(num_leaves, payload_sz);
  localparam int unsigned DstLo    = dst_lo(payload_sz);

  logic [p_sz-1:0] bus_q, bus_d;
  logic [15:0]     deflect_q, deflect_d;
  slot_e           slot_sel;

  logic                              bus_valid, hit;
  logic [AddrW-1:0]                  bus_dst;
  logic                              inj_push, inj_pop, inj_full, inj_empty;
  logic [p_sz-1:0]                   inj_din, inj_dout;
  logic [$clog2(inj_depth+1)-1:0]    inj_count;
  logic                              ej_push, ej_pop, ej_full, ej_empty;
  logic [$clog2(ej_depth+1)-1:0]     ej_count;

  assign bus_valid = bus_i[ValidIdx];
  assign bus_dst   = bus_i[DstHi:DstLo];
  assign hit       = bus_valid && (bus_dst == AddrW'(addr));

  // Injected words always leave as valid packets, whatever the PE put in the MSB.
  assign inj_din     = {1'b1, pe_in_data[p_sz-2:0]};
  assign pe_in_ready = !inj_full;
  assign inj_push    = pe_in_valid && !inj_full;

  assign pe_out_valid = !ej_empty;
  assign ej_pop       = !ej_empty && pe_out_ready;

  assign bus_o         = bus_q;
  assign deflect_count = deflect_q;

  // ej_full is the pre-pop flag, so a hit arriving alongside a pop of a full FIFO deflects.
  always_comb begin
    if (!bus_valid)    slot_sel = SlotIdle;
    else if (!hit)     slot_sel = SlotTransit;
    else if (!ej_full) slot_sel = SlotEject;
    else               slot_sel = SlotDeflect;
  end

  always_comb begin
    bus_d     = '0;
    ej_push   = 1'b0;
    inj_pop   = 1'b0;
    deflect_d = deflect_q;
    unique case (slot_sel)
      SlotTransit: bus_d = bus_i;
      SlotDeflect: begin
        bus_d = bus_i;
        if (deflect_q != DeflectMax) deflect_d = deflect_q + 16'd1;
      end
      SlotEject, SlotIdle: begin
        ej_push = (slot_sel == SlotEject);
        if (!inj_empty) begin
          bus_d   = inj_dout;
          inj_pop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_q     <= '0;
      deflect_q <= '0;
    end else begin
      bus_q     <= bus_d;
      deflect_q <= deflect_d;
    end
  end

  sync_fifo #(
    .WIDTH (p_sz),
    .DEPTH (inj_depth)
  ) u_inj_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inj_push),
    .din   (inj_din),
    .pop   (inj_pop),
    .dout  (inj_dout),
    .full  (inj_full),
    .empty (inj_empty),
    .count (inj_count)
  );

  sync_fifo #(
    .WIDTH (p_sz),
    .DEPTH (ej_depth)
  ) u_ej_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ej_push),
    .din   (bus_i),
    .pop   (ej_pop),
    .dout  (pe_out_data),
    .full  (ej_full),
    .empty (ej_empty),
    .count (ej_count)
  );

  logic unused_sigs;
  assign unused_sigs = ^{pe_in_data[p_sz-1], inj_count, ej_count};

endmodule

// File: tb/tb_buffered_ring_interface.sv
module tb_buffered_ring_interface;

  localparam int unsigned P = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [P-1:0] bus_i = '0;
  logic [P-1:0] bus_o;
  logic [P-1:0] pe_in_data = '0;
  logic         pe_in_valid = 1'b0;
  logic         pe_in_ready;
  logic [P-1:0] pe_out_data;
  logic         pe_out_valid;
  logic         pe_out_ready = 1'b0;
  logic [15:0]  deflect_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  buffered_ring_interface #(
    .num_leaves (4),
    .payload_sz (8),
    .addr       (1),
    .inj_depth  (4),
    .ej_depth   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_i         (bus_i),
    .bus_o         (bus_o),
    .pe_in_data    (pe_in_data),
    .pe_in_valid   (pe_in_valid),
    .pe_in_ready   (pe_in_ready),
    .pe_out_data   (pe_out_data),
    .pe_out_valid  (pe_out_valid),
    .pe_out_ready  (pe_out_ready),
    .deflect_count (deflect_count)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    total++; if (bus_o !== 11'h000) begin $display("FAIL reset_bus_o got %h want %h", bus_o, 11'h000); bad++; end
    total++; if (pe_out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", pe_out_valid); bad++; end
    total++; if (pe_in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", pe_in_ready); bad++; end
    total++; if (deflect_count !== 16'd0) begin $display("FAIL reset_deflect got %0d want 0", deflect_count); bad++; end
  endtask

  task automatic test_local_receive();
    bus_i = 11'h5A5;
    step();
    bus_i = 11'h000;
    total++; if (pe_out_valid !== 1'b1) begin $display("FAIL rx_valid got %b want 1", pe_out_valid); bad++; end
    total++; if (pe_out_data !== 11'h5A5) begin $display("FAIL rx_data got %h want 5a5", pe_out_data); bad++; end
    total++; if (bus_o !== 11'h000) begin $display("FAIL rx_bus_o got %h want 000", bus_o); bad++; end
    pe_out_ready = 1'b1;
    step();
    pe_out_ready = 1'b0;
    total++; if (pe_out_valid !== 1'b0) begin $display("FAIL rx_drained got %b want 0", pe_out_valid); bad++; end
  endtask

  task automatic test_transit_priority();
    bus_i = 11'h73C;
    pe_in_data = 11'h611;
    pe_in_valid = 1'b1;
    step();
    pe_in_valid = 1'b0;
    total++; if (bus_o !== 11'h73C) begin $display("FAIL tr_bus_o1 got %h want 73c", bus_o); bad++; end
    step();
    total++; if (bus_o !== 11'h73C) begin $display("FAIL tr_bus_o2 got %h want 73c", bus_o); bad++; end
    bus_i = 11'h000;
    step();
    total++; if (bus_o !== 11'h611) begin $display("FAIL tr_inj_out got %h want 611", bus_o); bad++; end
    step();
    total++; if (bus_o !== 11'h000) begin $display("FAIL tr_idle got %h want 000", bus_o); bad++; end
  endtask

  task automatic test_inject();
    bus_i = 11'h000;
    pe_in_data = 11'h211;
    pe_in_valid = 1'b1;
    step();
    pe_in_valid = 1'b0;
    total++; if (bus_o !== 11'h000) begin $display("FAIL inj_early got %h want 000", bus_o); bad++; end
    total++; if (pe_in_ready !== 1'b1) begin $display("FAIL inj_ready got %b want 1", pe_in_ready); bad++; end
    step();
    total++; if (bus_o !== 11'h611) begin $display("FAIL inj_out got %h want 611", bus_o); bad++; end
    step();
    total++; if (bus_o !== 11'h000) begin $display("FAIL inj_after got %h want 000", bus_o); bad++; end
  endtask

  task automatic test_deflect();
    pe_out_ready = 1'b0;
    bus_i = 11'h5A5;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus_o !== 11'h000) begin $display("FAIL dfl_queue%0d got %h want 000", i, bus_o); bad++; end
    end
    step();
    total++; if (bus_o !== 11'h5A5) begin $display("FAIL dfl_bus_o got %h want 5a5", bus_o); bad++; end
    total++; if (deflect_count !== 16'd1) begin $display("FAIL dfl_count1 got %0d want 1", deflect_count); bad++; end
    // One pop frees a slot for the next hit.
    bus_i = 11'h000;
    pe_out_ready = 1'b1;
    step();
    pe_out_ready = 1'b0;
    bus_i = 11'h5A5;
    step();
    total++; if (bus_o !== 11'h000) begin $display("FAIL dfl_requeue got %h want 000", bus_o); bad++; end
    total++; if (deflect_count !== 16'd1) begin $display("FAIL dfl_count_hold got %0d want 1", deflect_count); bad++; end
    // Pop and hit together on a full FIFO: the hit still deflects.
    pe_out_ready = 1'b1;
    step();
    total++; if (bus_o !== 11'h5A5) begin $display("FAIL dfl_popsame got %h want 5a5", bus_o); bad++; end
    total++; if (deflect_count !== 16'd2) begin $display("FAIL dfl_count2 got %0d want 2", deflect_count); bad++; end
    bus_i = 11'h000;
    for (int i = 0; i < 3; i++) begin
      total++; if (pe_out_valid !== 1'b1) begin $display("FAIL dfl_drain%0d got %b want 1", i, pe_out_valid); bad++; end
      step();
    end
    pe_out_ready = 1'b0;
    total++; if (pe_out_valid !== 1'b0) begin $display("FAIL dfl_empty got %b want 0", pe_out_valid); bad++; end
  endtask

  task automatic test_backpressure();
    logic [P-1:0] exp_pkt;
    bus_i = 11'h73C;
    pe_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (pe_in_ready !== 1'b1) begin $display("FAIL bp_ready%0d got %b want 1", i, pe_in_ready); bad++; end
      pe_in_data = 11'h611 + 11'(i);
      step();
      total++; if (bus_o !== 11'h73C) begin $display("FAIL bp_transit%0d got %h want 73c", i, bus_o); bad++; end
    end
    pe_in_valid = 1'b0;
    total++; if (pe_in_ready !== 1'b0) begin $display("FAIL bp_full got %b want 0", pe_in_ready); bad++; end
    bus_i = 11'h000;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pkt = 11'h611 + 11'(i);
      total++; if (bus_o !== exp_pkt) begin $display("FAIL bp_out%0d got %h want %h", i, bus_o, exp_pkt); bad++; end
      total++; if (pe_in_ready !== 1'b1) begin $display("FAIL bp_ready_after%0d got %b want 1", i, pe_in_ready); bad++; end
    end
    step();
    total++; if (bus_o !== 11'h000) begin $display("FAIL bp_idle got %h want 000", bus_o); bad++; end
  endtask

  task automatic test_reset_mid();
    // Clear the counter first so the target value of 3 is reached from a known base.
    reset = 1'b1;
    step();
    reset = 1'b0;
    pe_out_ready = 1'b0;
    bus_i = 11'h5A5;
    for (int i = 0; i < 4; i++) step();
    pe_in_data = 11'h613;
    pe_in_valid = 1'b1;
    step();
    pe_in_valid = 1'b0;
    step();
    step();
    total++; if (deflect_count !== 16'd3) begin $display("FAIL rm_pre_count got %0d want 3", deflect_count); bad++; end
    total++; if (pe_in_ready !== 1'b1) begin $display("FAIL rm_pre_ready got %b want 1", pe_in_ready); bad++; end
    bus_i = 11'h73C;
    pe_in_data = 11'h614;
    pe_in_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pe_in_valid = 1'b0;
    bus_i = 11'h000;
    total++; if (bus_o !== 11'h000) begin $display("FAIL rm_bus_o got %h want 000", bus_o); bad++; end
    total++; if (pe_out_valid !== 1'b0) begin $display("FAIL rm_out_valid got %b want 0", pe_out_valid); bad++; end
    total++; if (pe_in_ready !== 1'b1) begin $display("FAIL rm_in_ready got %b want 1", pe_in_ready); bad++; end
    total++; if (deflect_count !== 16'd0) begin $display("FAIL rm_count got %0d want 0", deflect_count); bad++; end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus_o !== 11'h000) begin $display("FAIL rm_stale%0d got %h want 000", i, bus_o); bad++; end
      total++; if (pe_out_valid !== 1'b0) begin $display("FAIL rm_stale_ej%0d got %b want 0", i, pe_out_valid); bad++; end
    end
  endtask

  initial begin
    test_reset();
    test_local_receive();
    test_transit_priority();
    test_inject();
    test_deflect();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
